// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset defaults and the F/D packet
// that the decode stage also consumes.
package fetch_pkg;

  localparam logic [31:0] RESETVEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Single-entry F/D output register: load on accept, clear on consume, flush on
// redirect or halt. The instruction reads as NOP whenever the entry is empty.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT,
  parameter logic [31:0] RESETVEC = RESETVEC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        flush,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output fetch_pkt_t  pkt
);

  fetch_pkt_t entry;

  // Load beats consume so that a same-cycle consume+accept is a replace.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      entry <= '{valid: 1'b0, inst: NOP_INST, pc: RESETVEC};
    end else if (flush) begin
      entry.valid <= 1'b0;
    end else if (load) begin
      entry <= '{valid: 1'b1, inst: load_inst, pc: load_pc};
    end else if (consume) begin
      entry.valid <= 1'b0;
    end
  end

  assign pkt = '{valid: entry.valid,
                 inst:  entry.valid ? entry.inst : NOP_INST,
                 pc:    entry.pc};

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives a single-outstanding
// request to the instruction RAM and registers returned words for decode.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESETVEC = RESETVEC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exception,
  output logic        halted,
  output logic        fetch_misaligned
);

  fetch_state_t state, state_d;
  logic [31:0]  fetch_pc, fetch_pc_d;
  logic         misaligned_d;
  logic         flush, accept, consume, bad_target;
  fetch_pkt_t   pkt;

  assign imem_ready = (state == S_REQ) && !(id_valid && id_stall);
  assign imem_addr  = fetch_pc;
  assign accept     = imem_valid && imem_ready && !redirect && !exception;
  assign consume    = id_valid && !id_stall;
  assign bad_target = redirect && (redirect_pc[1:0] != 2'b00);
  assign halted     = (state == S_HALT);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state;
    fetch_pc_d   = fetch_pc;
    misaligned_d = fetch_misaligned;
    flush        = 1'b0;
    if (state != S_HALT) begin
      if (exception || bad_target) begin
        // Exception outranks a simultaneous redirect, so it clears the misaligned cause.
        state_d      = S_HALT;
        misaligned_d = !exception;
        flush        = 1'b1;
      end else if (redirect) begin
        state_d    = S_REQ;
        fetch_pc_d = redirect_pc;
        flush      = 1'b1;
      end else begin
        if (accept) fetch_pc_d = fetch_pc + 32'd4;
        unique case (state)
          S_IDLE:  state_d = S_REQ;
          S_REQ:   if (id_valid && id_stall) state_d = S_HOLD;
          S_HOLD:  if (!id_stall) state_d = S_REQ;
          default: state_d = state;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state            <= S_IDLE;
      fetch_pc         <= RESETVEC;
      fetch_misaligned <= 1'b0;
    end else begin
      state            <= state_d;
      fetch_pc         <= fetch_pc_d;
      fetch_misaligned <= misaligned_d;
    end
  end

  fetch_out_reg #(
    .NOP_INST(NOP_INST),
    .RESETVEC(RESETVEC)
  ) u_out_reg (
    .clk      (clk),
    .resetb   (resetb),
    .flush    (flush),
    .load     (accept),
    .consume  (consume),
    .load_inst(imem_rdata),
    .load_pc  (fetch_pc),
    .pkt      (pkt)
  );

  assign id_valid = pkt.valid;
  assign id_inst  = pkt.inst;
  assign id_pc    = pkt.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: streaming, stall, redirect, halt and reset
// scenarios against hand-computed expectations.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        resetb;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exception;
  logic        halted;
  logic        fetch_misaligned;

  logic        comb_ram;
  logic        valid_manual;
  int          checks;
  int          errors;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // RAM model: either answers in the same cycle or under manual control.
  assign imem_valid = comb_ram ? imem_ready : valid_manual;
  assign imem_rdata = inst_of(imem_addr);

  imem_fetch_ctrl dut (
    .clk             (clk),
    .resetb          (resetb),
    .imem_ready      (imem_ready),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .id_valid        (id_valid),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_stall        (id_stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .exception       (exception),
    .halted          (halted),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    resetb = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    exception = 1'b0; comb_ram = 1'b1; valid_manual = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({imem_ready, imem_addr, id_valid, id_pc, id_inst, halted, fetch_misaligned}
        !== {1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b addr=%h vld=%b pc=%h inst=%h halt=%b mis=%b, want 0 0 0 0 %h 0 0",
               imem_ready, imem_addr, id_valid, id_pc, id_inst, halted, fetch_misaligned, NOP);
    end
    resetb = 1'b0;
    #1;
    checks++;
    if (imem_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: imem_ready=%b want 0", imem_ready);
    end
    cyc();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc, exp_inst;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      exp_pc   = (k > 0) ? 32'(4 * (k - 1)) : 32'h0;
      exp_inst = (k > 0) ? inst_of(exp_pc) : NOP;
      checks++;
      if ({imem_ready, imem_addr, id_valid, id_pc, id_inst}
          !== {1'b1, 32'(4 * k), (k > 0), exp_pc, exp_inst}) begin
        errors++;
        $display("FAIL stream_%0d: rdy=%b addr=%h vld=%b pc=%h inst=%h, want 1 %h %b %h %h",
                 k, imem_ready, imem_addr, id_valid, id_pc, id_inst, 32'(4 * k), (k > 0), exp_pc, exp_inst);
      end
    end
    cyc();
  endtask

  task automatic test_stall();
    int n;
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #1;
      checks++;
      if ({imem_ready, id_valid, id_pc, id_inst} !== {1'b0, 1'b1, 32'hC, inst_of(32'hC)}) begin
        errors++;
        $display("FAIL stall_%0d: rdy=%b vld=%b pc=%h inst=%h, want 0 1 0000000c %h",
                 i, imem_ready, id_valid, id_pc, id_inst, inst_of(32'hC));
      end
    end
    cyc();
    id_stall = 1'b0;
    n = 0;
    while (!(id_valid && id_pc !== 32'hC) && n < 6) begin
      cyc();
      n++;
    end
    checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h10, inst_of(32'h10)}) begin
      errors++;
      $display("FAIL stall_resume: vld=%b pc=%h inst=%h, want 1 00000010 %h",
               id_valid, id_pc, id_inst, inst_of(32'h10));
    end
    cyc();
    checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h14, inst_of(32'h14)}) begin
      errors++;
      $display("FAIL stall_next: vld=%b pc=%h inst=%h, want 1 00000014 %h",
               id_valid, id_pc, id_inst, inst_of(32'h14));
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++;
    if ({imem_ready, imem_addr} !== {1'b1, 32'h18}) begin
      errors++;
      $display("FAIL redir_pending: rdy=%b addr=%h, want 1 00000018", imem_ready, imem_addr);
    end
    cyc();
    redirect = 1'b0;
    #1;
    checks++;
    if ({imem_ready, imem_addr, id_valid, id_inst} !== {1'b1, 32'h100, 1'b0, NOP}) begin
      errors++;
      $display("FAIL redir_flush: rdy=%b addr=%h vld=%b inst=%h, want 1 00000100 0 %h",
               imem_ready, imem_addr, id_valid, id_inst, NOP);
    end
    cyc();
    checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h100, inst_of(32'h100)}) begin
      errors++;
      $display("FAIL redir_target: vld=%b pc=%h inst=%h, want 1 00000100 %h",
               id_valid, id_pc, id_inst, inst_of(32'h100));
    end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #1;
      checks++;
      if ({halted, fetch_misaligned, imem_ready, id_valid} !== 4'b1100) begin
        errors++;
        $display("FAIL misaligned_%0d: halt=%b mis=%b rdy=%b vld=%b, want 1 1 0 0",
                 i, halted, fetch_misaligned, imem_ready, id_valid);
      end
    end
  endtask

  task automatic test_exc_redirect();
    resetb = 1'b1;
    #1;
    checks++;
    if ({halted, fetch_misaligned, imem_ready, imem_addr, id_valid} !== {4'b0000, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: halt=%b mis=%b rdy=%b addr=%h vld=%b, want 0 0 0 0 0",
               halted, fetch_misaligned, imem_ready, imem_addr, id_valid);
    end
    cyc();
    resetb = 1'b0;
    cyc();
    cyc();
    exception = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    exception = 1'b0; redirect = 1'b0;
    #1;
    checks++;
    if ({halted, fetch_misaligned, imem_ready, imem_addr, id_valid} !== {3'b100, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL exc_wins: halt=%b mis=%b rdy=%b addr=%h vld=%b, want 1 0 0 00000004 0",
               halted, fetch_misaligned, imem_ready, imem_addr, id_valid);
    end
    comb_ram = 1'b0; valid_manual = 1'b0;
    resetb = 1'b1;
    cyc();
    resetb = 1'b0;
    cyc();
    checks++;
    if ({halted, imem_ready, imem_addr, id_valid} !== {2'b01, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL restart: halt=%b rdy=%b addr=%h vld=%b, want 0 1 00000000 0",
               halted, imem_ready, imem_addr, id_valid);
    end
  endtask

  task automatic test_latency_reset();
    cyc();
    checks++;
    if ({imem_ready, imem_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wait_stable: rdy=%b addr=%h vld=%b, want 1 00000000 0", imem_ready, imem_addr, id_valid);
    end
    cyc();
    valid_manual = 1'b1;
    cyc();
    valid_manual = 1'b0;
    #1;
    checks++;
    if ({imem_ready, imem_addr, id_valid, id_pc, id_inst} !== {1'b1, 32'h4, 1'b1, 32'h0, inst_of(32'h0)}) begin
      errors++;
      $display("FAIL slow_accept: rdy=%b addr=%h vld=%b pc=%h inst=%h, want 1 00000004 1 00000000 %h",
               imem_ready, imem_addr, id_valid, id_pc, id_inst, inst_of(32'h0));
    end
    cyc();
    resetb = 1'b1; valid_manual = 1'b1;
    #1;
    checks++;
    if ({imem_ready, imem_addr, id_valid, id_pc, id_inst, halted, fetch_misaligned}
        !== {1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreq_reset: rdy=%b addr=%h vld=%b pc=%h inst=%h halt=%b mis=%b, want 0 0 0 0 %h 0 0",
               imem_ready, imem_addr, id_valid, id_pc, id_inst, halted, fetch_misaligned, NOP);
    end
    cyc();
    resetb = 1'b0;
    #1;
    checks++;
    if ({imem_ready, id_valid, imem_addr} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL late_valid_idle: rdy=%b vld=%b addr=%h, want 0 0 00000000", imem_ready, id_valid, imem_addr);
    end
    cyc();
    checks++;
    if ({imem_ready, id_valid, imem_addr} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL reenter_req: rdy=%b vld=%b addr=%h, want 1 0 00000000", imem_ready, id_valid, imem_addr);
    end
    cyc();
    valid_manual = 1'b0;
    checks++;
    if ({id_valid, id_pc, imem_addr} !== {1'b1, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL reenter_accept: vld=%b pc=%h addr=%h, want 1 00000000 00000004", id_valid, id_pc, imem_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_exc_redirect();
    test_latency_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
